// File: rtl/grf_pkg.sv
// Shared definitions for the write-back general register file.
// Contents:
//   DATA_W, ADDR_W   default data width and register index width
//   REG_ZERO         index of the hardwired-zero register
//   REG_RA           index of the link register written by jal
//   reg_idx_t        register index type
//   word_t           register data type
package grf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/grf_read_port.sv
// One combinational read port of the register file.
// The port returns zero for register $0 and, when BYPASS is set, forwards
// the write data of a same-cycle write to the register being read.
// The forward is suppressed while reset is held so reads stay at zero.
// Ports:
//   reset_n  asynchronous active-low reset (gates the forward only)
//   ra       read index
//   stored   current array contents at index ra
//   we, wa   write enable and destination of the write port
//   wd       write data of the write port
//   rd       read data
module grf_read_port #(
  parameter int DATA_W = grf_pkg::DATA_W,
  parameter int ADDR_W = grf_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] stored,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  import grf_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  always_comb begin
    rd = stored;
    if (ra == ZERO_IDX) begin
      rd = '0;
    end else if ((BYPASS != 0) && reset_n && we && (wa == ra)) begin
      // we is tested first so an X destination with we=0 cannot disturb rd
      rd = wd;
    end
  end

endmodule

// File: rtl/wb_grf.sv
// General register file at the consuming end of the write-back path.
// Holds 2**ADDR_W-1 writable registers ($0 reads as zero), one W-stage
// write port and two combinational D-stage read ports with optional
// same-cycle write-through, plus a count of committed non-$0 writes.
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   ra1, ra2  read indices (rs, rt)
//   rd1, rd2  read data
//   we, wa    W-stage write enable and destination
//   wd        W-stage write data
//   w_pc      PC of the writing instruction (trace only)
//   wr_count  committed non-$0 writes since reset, wraps at 2**32
// Build option:
//   GRF_TRACE_EN  when defined, each committed write prints a simulation
//                 trace line "<time> @<pc>: $<nn> <= <data>".
module wb_grf #(
  parameter int DATA_W = grf_pkg::DATA_W,
  parameter int ADDR_W = grf_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] w_pc,
  output logic [31:0]       wr_count
);

  import grf_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  // Writes to $0 are dropped entirely: no storage update, no count.
  assign commit = we && (wa != ZERO_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (commit) begin
      regs[wa] <= wd;
      wr_count <= wr_count + 32'd1;
    end
  end

  grf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port1 (
    .reset_n (reset_n),
    .ra      (ra1),
    .stored  (regs[ra1]),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .rd      (rd1)
  );

  grf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port2 (
    .reset_n (reset_n),
    .ra      (ra2),
    .stored  (regs[ra2]),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .rd      (rd2)
  );

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (reset_n && commit) begin
      $display("%0t @%08h: $%02d <= %08h", $time, w_pc, wa, wd);
    end
  end
`else
  logic unused_w_pc;
  assign unused_w_pc = ^w_pc;
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf. Two instances share all inputs: one with
// write-through forwarding, one without. Stimulus pushes expected values
// into a queue; a monitor pops and compares them against the outputs.
module tb_wb_grf;

  localparam int DW = 32;
  localparam int AW = 5;

  // output selectors
  localparam int S_RD1    = 0;
  localparam int S_RD2    = 1;
  localparam int S_CNT    = 2;
  localparam int S_NB_RD1 = 3;
  localparam int S_NB_RD2 = 4;
  localparam int S_NB_CNT = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] wd, w_pc;
  logic          we;
  logic [DW-1:0] rd1, rd2, nb_rd1, nb_rd2;
  logic [31:0]   wr_count, nb_wr_count;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  always #5 clk = ~clk;

  wb_grf #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .w_pc     (w_pc),
    .wr_count (wr_count)
  );

  wb_grf #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nb (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (nb_rd1),
    .rd2      (nb_rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .w_pc     (w_pc),
    .wr_count (nb_wr_count)
  );

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_RD1:    return rd1;
      S_RD2:    return rd2;
      S_CNT:    return wr_count;
      S_NB_RD1: return nb_rd1;
      S_NB_RD2: return nb_rd2;
      default:  return nb_wr_count;
    endcase
  endfunction

  // Monitor: samples 1 time unit after an expectation appears, which is
  // always well clear of the rising edge (stimulus changes at the falling
  // edge or mid-low-phase).
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      wait (sb_q.size() != 0);
      #1;
      while (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        act = pick(e.sel);
        chk_cnt++;
        if (act === e.exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_out(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  // Hold inputs until the monitor has consumed every expectation.
  task automatic drain();
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) #1;
    if (sb_q.size() != 0) begin
      chk_cnt += sb_q.size();
      $display("FAIL drain: %0d expectations never consumed, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0; w_pc = '0;
    ra1 = '0; ra2 = '0;
    step();
    ra1 = 5'd5;
    expect_out("reset_rd1", S_RD1, 32'h0);
    expect_out("reset_cnt", S_CNT, 32'h0);
    drain();
    reset_n = 1'b1;

    // basic write then read on both ports
    we = 1'b1; wa = 5'd8; wd = 32'hDEADBEEF;
    step();
    we = 1'b0; ra1 = 5'd8; ra2 = 5'd8;
    expect_out("basic_rd1", S_RD1, 32'hDEADBEEF);
    expect_out("basic_rd2", S_RD2, 32'hDEADBEEF);
    expect_out("basic_nb_rd1", S_NB_RD1, 32'hDEADBEEF);
    expect_out("basic_cnt", S_CNT, 32'd1);
    drain();

    // write to $0 is discarded
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0;
    expect_out("zero_same_rd1", S_RD1, 32'h0);
    expect_out("zero_same_nb_rd1", S_NB_RD1, 32'h0);
    drain();
    step();
    we = 1'b0;
    expect_out("zero_next_rd1", S_RD1, 32'h0);
    expect_out("zero_cnt", S_CNT, 32'd1);
    drain();

    // bypass: $9=0x11 stored, then same-cycle write of 0x22
    we = 1'b1; wa = 5'd9; wd = 32'h11;
    step();
    wd = 32'h22; ra1 = 5'd9;
    expect_out("byp_pre_rd1", S_RD1, 32'h22);
    expect_out("nobyp_pre_rd1", S_NB_RD1, 32'h11);
    drain();
    step();
    we = 1'b0;
    expect_out("byp_post_rd1", S_RD1, 32'h22);
    expect_out("nobyp_post_rd1", S_NB_RD1, 32'h22);
    expect_out("byp_cnt", S_CNT, 32'd3);
    drain();

    // jal link write to $31
    we = 1'b1; wa = 5'd31; wd = 32'h00003008; w_pc = 32'h00003000;
    step();
    we = 1'b0; ra1 = 5'd31;
    expect_out("jal_rd1", S_RD1, 32'h00003008);
    expect_out("jal_cnt", S_CNT, 32'd4);
    drain();

    // back-to-back writes to $3 with ra2 held
    ra2 = 5'd3; we = 1'b1; wa = 5'd3;
    wd = 32'h1;
    expect_out("b2b_1_rd2", S_RD2, 32'h1);
    expect_out("b2b_1_nb_rd2", S_NB_RD2, 32'h0);
    drain();
    step();
    wd = 32'h2;
    expect_out("b2b_2_rd2", S_RD2, 32'h2);
    expect_out("b2b_2_nb_rd2", S_NB_RD2, 32'h1);
    drain();
    step();
    wd = 32'h3;
    expect_out("b2b_3_rd2", S_RD2, 32'h3);
    expect_out("b2b_3_nb_rd2", S_NB_RD2, 32'h2);
    drain();
    step();
    we = 1'b0;
    expect_out("b2b_hold_rd2", S_RD2, 32'h3);
    expect_out("b2b_hold_nb_rd2", S_NB_RD2, 32'h3);
    expect_out("b2b_cnt", S_CNT, 32'd7);
    drain();

    // X on wa/wd with we=0 must not disturb anything
    wa = 'x; wd = 'x; ra1 = 5'd8;
    expect_out("xin_rd1", S_RD1, 32'hDEADBEEF);
    drain();
    step();
    expect_out("xin_next_rd1", S_RD1, 32'hDEADBEEF);
    expect_out("xin_cnt", S_CNT, 32'd7);
    drain();

    // store $5, then assert reset during an active write
    we = 1'b1; wa = 5'd5; wd = 32'h1234;
    step();
    we = 1'b0; ra1 = 5'd5;
    expect_out("pre_rst_rd1", S_RD1, 32'h1234);
    expect_out("pre_rst_cnt", S_CNT, 32'd8);
    drain();
    we = 1'b1; wa = 5'd5; wd = 32'h5555;
    #2 reset_n = 1'b0;
    expect_out("midrst_rd1", S_RD1, 32'h0);
    expect_out("midrst_nb_rd1", S_NB_RD1, 32'h0);
    expect_out("midrst_cnt", S_CNT, 32'h0);
    expect_out("midrst_nb_cnt", S_NB_CNT, 32'h0);
    drain();
    step();
    expect_out("rst_held_rd1", S_RD1, 32'h0);
    expect_out("rst_held_cnt", S_CNT, 32'h0);
    drain();
    reset_n = 1'b1; we = 1'b0; ra1 = 5'd8;
    expect_out("post_rst_r8", S_RD1, 32'h0);
    drain();

    // first write after release
    we = 1'b1; wa = 5'd6; wd = 32'hA5;
    step();
    we = 1'b0; ra1 = 5'd6;
    expect_out("post_rst_wr_rd1", S_RD1, 32'hA5);
    expect_out("post_rst_wr_cnt", S_CNT, 32'd1);
    drain();

    step();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- General register file at the consuming end of the write-back path. It accepts the W-stage write (destination, selected write data, PC) and serves two combinational read ports to the D stage.
- Holds 31 writable 32-bit registers; $0 is hardwired to zero.
- Internal write-through bypass: a D-stage read of the register being written in the same cycle returns the new data. This removes the W→D forwarding case from the hazard unit.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = read returns the pre-write value

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- ra1  input  ADDR_W  read port 1 index (rs)
- ra2  input  ADDR_W  read port 2 index (rt)
- rd1  output  DATA_W  read port 1 data
- rd2  output  DATA_W  read port 2 data
- we  input  1  W-stage write enable
- wa  input  ADDR_W  W-stage destination index
- wd  input  DATA_W  W-stage write data (already muxed from ALU result / memory data / PC+8)
- w_pc  input  DATA_W  PC of the writing instruction; used only by the trace feature
- wr_count  output  32  number of committed non-$0 writes since reset

Behaviour:
- Reset:
  - reset_n low asynchronously clears registers 1..31 to 0 and wr_count to 0.
  - rd1/rd2 read 0 while reset is held.
  - On release, the first write can take effect at the first rising edge with reset_n high.
- Write:
  - On the rising edge with we=1 and wa!=0, reg[wa] <= wd and wr_count increments by 1 (wraps modulo 2**32).
  - we=1 with wa=0 is discarded: no state change, no count increment.
- Read:
  - Combinational, zero latency.
  - rdN = 0 when raN=0, regardless of any write to $0.
  - Otherwise, with BYPASS=1: if we=1 and wa==raN, rdN = wd; else rdN = reg[raN].
  - With BYPASS=0: rdN = reg[raN] (old value until the edge).
- Simultaneous events:
  - Both read ports may address the same register, and may both match wa; both are bypassed identically.
  - A single write port means there are no write-write conflicts.
- Reset mid-operation: asserting reset_n during an active write cycle clears all state. The write is lost; the async clear wins over the edge.
- X handling: when we=0, wa/wd may be X without affecting state or reads.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: on every committed write (we=1, wa!=0, sampled at the rising edge), the block emits one simulation display line, `@<w_pc hex 8>: $<wa decimal 2> <= <wd hex 8>`, with time prefix `<$time>`. Writes to $0 print nothing. Synthesis is unaffected; the feature is simulation-only.
- Undefined: no display code; w_pc is unused.

Decomposition:
- Shared package grf_pkg:
  - localparams DATA_W=32, ADDR_W=5, REG_ZERO=5'd0, REG_RA=5'd31
  - typedef reg_idx_t (ADDR_W bits)
  - typedef word_t (DATA_W bits)
- One natural sub-module, grf_read_port:
  - Implements the zero-check plus bypass compare/mux for a single port.
  - Instantiated twice (rd1, rd2).
  - Storage array and wr_count stay in wb_grf.

Test Plan:
- Reset: hold reset_n=0 mid-simulation after writing $5=0x1234 → rd1 (ra1=5) reads 0 immediately (asynchronous, no clock edge); wr_count=0.
- Basic write/read: we=1, wa=8, wd=0xDEADBEEF at edge; next cycle ra1=8, ra2=8 → rd1=rd2=0xDEADBEEF; wr_count=1.
- $0 immutability: we=1, wa=0, wd=0xFFFFFFFF → rd1 (ra1=0)=0 in the same and next cycle; wr_count unchanged; with GRF_TRACE_EN no line is printed.
- Bypass: $9=0x11 stored; same cycle apply we=1, wa=9, wd=0x22, ra1=9 → BYPASS=1: rd1=0x22 before the edge; BYPASS=0: rd1=0x11 before the edge, 0x22 after.
- jal link path: we=1, wa=31, wd=0x00003008, w_pc=0x00003000 → reg31=0x00003008; trace prints `@00003000: $31 <= 00003008`.
- Back-to-back writes to the same register (0x1, then 0x2, then 0x3 to $3 on consecutive edges), with ra2=3 held → rd2 follows 0x1/0x2/0x3 each cycle (bypassed); wr_count=3.
